mem_lane_sched: RTL and testbench
=================================

Name: mem_lane_sched

Overview:
- Sits directly upstream of the four-lane instruction swap stage.
- Accepts a 4-thread instruction group from decode.
- Guarantees at most one valid load/store per issued group. When a group holds several, it splits the group over successive cycles.
- Drives the per-lane swap flags so the swap stage moves the memory op to lane 4.
- Output is registered, with a valid/ready handshake.

Parameters:
- REG_W, 5, width of des/s1/s2 register specifiers.
- OP_W, 4, opcode width.
- IME_W, 16, immediate width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- in_valid  in  1  group offered by decode.
- in_ready  out  1  group accepted when in_valid && in_ready.
- in_vld  in  4  per-lane instruction valid; bit i = thread i+1.
- in_des  in  4*REG_W  destination per lane.
- in_s1  in  4*REG_W  source 1 per lane.
- in_s2  in  4*REG_W  source 2 per lane.
- in_op  in  4*OP_W  opcode per lane.
- in_ime  in  4*IME_W  immediate per lane.
- in_branch  in  4  branch flag per lane.
- out_valid  out  1  registered group valid.
- out_ready  in  1  swap/issue stage accepts.
- out_vld, out_des, out_s1, out_s2, out_op, out_ime, out_branch  out  same widths as inputs  issued group.
- ins1_swap, ins2_swap, ins3_swap, ins4_swap  out  1 each  swap control to next stage.
- out_tid  out  8  original thread index (2 bits) per output lane, for writeback.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: out_valid=0, in_ready=1, all out_* fields 0, swap flags 0, out_tid = {3,2,1,0}, state=IDLE, pending mask 0.
- Memory-op detection: lane i is a mem op iff in_vld[i] and op equals OP_LOAD or OP_STORE. Invalid lanes are never mem ops.
- States:
  - IDLE: in_ready=1 when the output register is empty or being drained (out_ready). On accept, compute mask M of mem lanes.
  - |M|<=1: issue the full group next cycle; stay IDLE.
  - |M|>=2: issue all non-mem lanes plus the lowest-index mem lane. Other mem lanes are issued with vld=0. Latch the group and pending mask P = M minus the issued lane. Go to DRAIN.
  - DRAIN: in_ready=0. Each time the output register is free, issue the lowest-index lane of P alone (all other vld=0). Clear it from P. Return to IDLE when P becomes empty.
- Lane placement, for the single mem lane k of an issued group:
  - k=4 or no mem op: lanes unchanged; flags 0000.
  - k=1: lanes unchanged; flags 1001.
  - k=2 or 3: the block exchanges lane k and lane 1 in its output register and sets flags 1001. Net effect after the swap stage: mem op in lane 4.
  - Flags 1100/1010 are never generated.
- out_tid: reflects the block's own exchange only. Lane j reports the source thread index of what it drives; the identity mapping is {3,2,1,0}.
- Latency: 1 cycle from accept to out_valid for unsplit groups. A split group with n mem ops occupies n output beats.
- Backpressure: while out_valid && !out_ready, all outputs hold stable and no state advances.
- Empty group (in_vld=0000) accepted: issued as a valid beat with flags 0000.
- Branch lanes: treated as non-mem lanes. in_branch passes through with its lane.
- Reset mid-DRAIN: pending lanes are discarded, state returns to IDLE, out_valid=0 the next cycle.

Decomposition:
- Package mem_sched_pkg:
  - OP_LOAD and OP_STORE opcode constants.
  - Widths.
  - Lane struct typedef {vld, des, s1, s2, op, ime, branch}.
  - State enum {IDLE, DRAIN}.
- One sub-module, mem_lane_pick: combinational. Takes a 4-bit mask and returns the lowest-set index plus a one-hot mask. Used for both M and P.

Test Plan:
- Only lane 4 is load (op=OP_LOAD), all lanes valid -> one beat one cycle later, flags 0000, lanes unchanged, out_tid {3,2,1,0}.
- Only lane 1 is store -> one beat, flags 1001, lanes unchanged.
- Only lane 3 is load -> one beat, flags 1001, out lane1 = in lane3, out lane3 = in lane1, out_tid {3,0,1,2}.
- Lanes 2 and 4 both load -> beat 1: lanes 1, 3 and mem lane 2 valid, lane 4 vld=0, flags 1001. Beat 2: only lane 4 valid, flags 0000. in_ready=0 during DRAIN.
- out_ready held 0 for 3 cycles during the first beat of the previous case -> outputs stable, second beat issues only after the handshake.
- rst asserted in DRAIN -> next cycle out_valid=0, in_ready=1, pending load not issued.

Source files
------------

// File: rtl/mem_lane_sched_pkg.sv
// Shared types and constants for the memory-lane scheduler: lane record,
// FSM states and opcode decoding.
package mem_sched_pkg;

    localparam int NUM_LANES  = 4;
    localparam int LANE_REG_W = 5;
    localparam int LANE_OP_W  = 4;
    localparam int LANE_IME_W = 16;

    localparam logic [LANE_OP_W-1:0] OP_LOAD  = 4'h8;
    localparam logic [LANE_OP_W-1:0] OP_STORE = 4'h9;

    // out_tid when no lanes are exchanged: lane j carries thread j
    localparam logic [7:0] TID_IDENT = 8'b11_10_01_00;

    typedef struct packed {
        logic                  vld;
        logic [LANE_REG_W-1:0] des;
        logic [LANE_REG_W-1:0] s1;
        logic [LANE_REG_W-1:0] s2;
        logic [LANE_OP_W-1:0]  op;
        logic [LANE_IME_W-1:0] ime;
        logic                  branch;
    } lane_t;

    typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_e;

    function automatic logic is_mem(lane_t l);
        return l.vld && (l.op == OP_LOAD || l.op == OP_STORE);
    endfunction

endpackage

// File: rtl/mem_lane_sched_if.sv
// Decode-side and issue-side bundle of the memory-lane scheduler; the
// master drives groups and accepts beats, the slave is the scheduler.
interface mem_lane_sched_if #(
    parameter int REG_W = 5,
    parameter int OP_W  = 4,
    parameter int IME_W = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [3:0]         in_vld;
    logic [4*REG_W-1:0] in_des;
    logic [4*REG_W-1:0] in_s1;
    logic [4*REG_W-1:0] in_s2;
    logic [4*OP_W-1:0]  in_op;
    logic [4*IME_W-1:0] in_ime;
    logic [3:0]         in_branch;

    logic               out_valid;
    logic               out_ready;
    logic [3:0]         out_vld;
    logic [4*REG_W-1:0] out_des;
    logic [4*REG_W-1:0] out_s1;
    logic [4*REG_W-1:0] out_s2;
    logic [4*OP_W-1:0]  out_op;
    logic [4*IME_W-1:0] out_ime;
    logic [3:0]         out_branch;
    logic               ins1_swap;
    logic               ins2_swap;
    logic               ins3_swap;
    logic               ins4_swap;
    logic [7:0]         out_tid;

    modport master (
        output in_valid, in_vld, in_des, in_s1, in_s2, in_op, in_ime, in_branch, out_ready,
        input  in_ready, out_valid, out_vld, out_des, out_s1, out_s2, out_op, out_ime,
               out_branch, ins1_swap, ins2_swap, ins3_swap, ins4_swap, out_tid
    );

    modport slave (
        input  in_valid, in_vld, in_des, in_s1, in_s2, in_op, in_ime, in_branch, out_ready,
        output in_ready, out_valid, out_vld, out_des, out_s1, out_s2, out_op, out_ime,
               out_branch, ins1_swap, ins2_swap, ins3_swap, ins4_swap, out_tid
    );
endinterface

// File: rtl/mem_lane_pick.sv
// Lowest-set-bit picker over a 4-lane mask: index, one-hot and any flag.
module mem_lane_pick (
    input  logic [3:0] mask_i,
    output logic [1:0] idx_o,
    output logic [3:0] onehot_o,
    output logic       any_o
);
    always_comb begin
        idx_o = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask_i[i]) idx_o = 2'(i);
        end
        any_o    = |mask_i;
        onehot_o = any_o ? (4'b0001 << idx_o) : 4'b0000;
    end
endmodule

// File: rtl/mem_lane_sched.sv
// Splits decode groups so each issued beat carries at most one load/store,
// and pre-places that op so the downstream swap stage lands it in lane 4.
module mem_lane_sched
    import mem_sched_pkg::*;
#(
    parameter int REG_W = LANE_REG_W,
    parameter int OP_W  = LANE_OP_W,
    parameter int IME_W = LANE_IME_W
) (
    input  logic            clk,
    input  logic            rst,
    mem_lane_sched_if.slave bus
);
    lane_t [NUM_LANES-1:0] in_lane, grp_q, grp_d, out_q, out_d, src, staged;
    state_e                state_q, state_d;
    logic [3:0]            mem_m, oh_m, oh_p, pend_q, pend_d, issue_vld;
    logic [1:0]            k_m, k_p, k_iss;
    logic                  any_m, any_p, iss_mem, issue;
    logic                  out_valid_q, out_valid_d, swap_q, swap_d;
    logic [7:0]            tid_q, tid_d;
    logic                  out_free, accept, split;

    always_comb begin
        in_lane = '0;
        mem_m   = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            in_lane[i].vld    = bus.in_vld[i];
            in_lane[i].des    = bus.in_des[i*REG_W +: REG_W];
            in_lane[i].s1     = bus.in_s1[i*REG_W +: REG_W];
            in_lane[i].s2     = bus.in_s2[i*REG_W +: REG_W];
            in_lane[i].op     = bus.in_op[i*OP_W +: OP_W];
            in_lane[i].ime    = bus.in_ime[i*IME_W +: IME_W];
            in_lane[i].branch = bus.in_branch[i];
            mem_m[i]          = is_mem(in_lane[i]);
        end
    end

    mem_lane_pick u_pick_m (.mask_i(mem_m),  .idx_o(k_m), .onehot_o(oh_m), .any_o(any_m));
    mem_lane_pick u_pick_p (.mask_i(pend_q), .idx_o(k_p), .onehot_o(oh_p), .any_o(any_p));

    assign out_free = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && bus.in_ready;
    assign split    = accept && |(mem_m & ~oh_m);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            grp_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            swap_q      <= 1'b0;
            tid_q       <= TID_IDENT;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            grp_q       <= grp_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            swap_q      <= swap_d;
            tid_q       <= tid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        grp_d   = grp_q;
        case (state_q)
            IDLE: if (split) begin
                state_d = DRAIN;
                pend_d  = mem_m & ~oh_m;
                grp_d   = in_lane;
            end
            DRAIN: if (out_free) begin
                pend_d = pend_q & ~oh_p;
                if ((pend_q & ~oh_p) == 4'b0000) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = (state_q == IDLE) && out_free;
    end

    // Beat source: the live group in IDLE, the latched group while draining.
    always_comb begin
        src       = in_lane;
        issue_vld = bus.in_vld;
        k_iss     = k_m;
        iss_mem   = any_m;
        issue     = accept;
        if (state_q == DRAIN) begin
            src       = grp_q;
            issue_vld = oh_p;
            k_iss     = k_p;
            iss_mem   = any_p;
            issue     = out_free;
        end else if (split) begin
            issue_vld = bus.in_vld & ~(mem_m & ~oh_m);
        end

        staged = src;
        for (int i = 0; i < NUM_LANES; i++) staged[i].vld = issue_vld[i];

        out_d       = out_q;
        out_valid_d = out_valid_q;
        swap_d      = swap_q;
        tid_d       = tid_q;
        if (out_free) begin
            out_valid_d = issue;
            if (issue) begin
                out_d  = staged;
                tid_d  = TID_IDENT;
                swap_d = iss_mem && (k_iss != 2'd3);
                // Lanes 2/3 are moved to lane 1 here; the 1<->4 swap downstream finishes the job.
                if (iss_mem && (k_iss == 2'd1 || k_iss == 2'd2)) begin
                    out_d[0]            = staged[k_iss];
                    out_d[k_iss]        = staged[0];
                    tid_d[1:0]          = k_iss;
                    tid_d[2*k_iss +: 2] = 2'd0;
                end
            end
        end
    end

    always_comb begin
        bus.out_vld    = '0;
        bus.out_des    = '0;
        bus.out_s1     = '0;
        bus.out_s2     = '0;
        bus.out_op     = '0;
        bus.out_ime    = '0;
        bus.out_branch = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            bus.out_vld[i]                = out_q[i].vld;
            bus.out_des[i*REG_W +: REG_W] = out_q[i].des;
            bus.out_s1[i*REG_W +: REG_W]  = out_q[i].s1;
            bus.out_s2[i*REG_W +: REG_W]  = out_q[i].s2;
            bus.out_op[i*OP_W +: OP_W]    = out_q[i].op;
            bus.out_ime[i*IME_W +: IME_W] = out_q[i].ime;
            bus.out_branch[i]             = out_q[i].branch;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_tid   = tid_q;
    assign bus.ins1_swap = swap_q;
    assign bus.ins2_swap = 1'b0;
    assign bus.ins3_swap = 1'b0;
    assign bus.ins4_swap = swap_q;

endmodule

// File: tb/tb_mem_lane_sched.sv
// Bench for mem_lane_sched: directed scenarios plus random traffic, checked
// against a queue-of-beats reference model built from the lane rules.
module tb_mem_lane_sched;
    import mem_sched_pkg::*;

    localparam logic [3:0] OP_ALU = 4'h1;

    typedef struct packed {
        logic [3:0]  vld;
        logic [19:0] des, s1, s2;
        logic [15:0] op;
        logic [63:0] ime;
        logic [3:0]  br;
    } grp_t;

    typedef struct packed {
        logic [3:0]  vld;
        logic [3:0]  flg;
        logic [7:0]  tid;
        logic [19:0] des, s1, s2;
        logic [15:0] op;
        logic [63:0] ime;
        logic [3:0]  br;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_lane_sched_if bus ();
    mem_lane_sched dut (.clk(clk), .rst(rst), .bus(bus));

    beat_t        exp_q[$];
    int           nchk = 0;
    int           nfail = 0;
    logic         hold_armed = 1'b0;
    logic [255:0] snap;
    grp_t         cur;

    task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic mem_op(grp_t g, int i);
        return g.vld[i] && (g.op[i*4 +: 4] == OP_LOAD || g.op[i*4 +: 4] == OP_STORE);
    endfunction

    // One issued beat: lanes v of group g, with the single mem lane placed.
    function automatic beat_t place(grp_t g, logic [3:0] v);
        beat_t b;
        int k = -1;
        int perm[4] = '{0, 1, 2, 3};
        for (int i = 0; i < 4; i++) if (v[i] && mem_op(g, i)) k = i;
        if (k == 1 || k == 2) begin
            perm[0] = k;
            perm[k] = 0;
        end
        b.flg = (k >= 0 && k <= 2) ? 4'b1001 : 4'b0000;
        for (int j = 0; j < 4; j++) begin
            int s = perm[j];
            b.vld[j]         = v[s];
            b.des[j*5 +: 5]  = g.des[s*5 +: 5];
            b.s1[j*5 +: 5]   = g.s1[s*5 +: 5];
            b.s2[j*5 +: 5]   = g.s2[s*5 +: 5];
            b.op[j*4 +: 4]   = g.op[s*4 +: 4];
            b.ime[j*16 +: 16] = g.ime[s*16 +: 16];
            b.br[j]          = g.br[s];
            b.tid[j*2 +: 2]  = 2'(s);
        end
        return b;
    endfunction

    function automatic void model_push(grp_t g);
        int mem[$];
        logic [3:0] v = g.vld;
        for (int i = 0; i < 4; i++) if (mem_op(g, i)) mem.push_back(i);
        for (int j = 1; j < mem.size(); j++) v[mem[j]] = 1'b0;
        exp_q.push_back(place(g, v));
        for (int j = 1; j < mem.size(); j++) exp_q.push_back(place(g, 4'(1 << mem[j])));
    endfunction

    function automatic logic [63:0] mexp(logic [3:0] v, int w);
        logic [63:0] m = '0;
        for (int i = 0; i < 4; i++)
            for (int b = 0; b < w; b++) m[i*w + b] = v[i];
        return m;
    endfunction

    function automatic logic [255:0] outs();
        return 256'({bus.out_valid, bus.out_vld, bus.out_des, bus.out_s1, bus.out_s2, bus.out_op,
                     bus.out_ime, bus.out_branch, bus.out_tid, bus.ins1_swap, bus.ins2_swap,
                     bus.ins3_swap, bus.ins4_swap});
    endfunction

    function automatic logic [3:0] flags();
        return {bus.ins1_swap, bus.ins2_swap, bus.ins3_swap, bus.ins4_swap};
    endfunction

    function automatic grp_t rnd_grp();
        grp_t g;
        g.vld = 4'($urandom);
        g.des = 20'($urandom);
        g.s1  = 20'($urandom);
        g.s2  = 20'($urandom);
        g.ime = {$urandom, $urandom};
        g.br  = 4'($urandom);
        for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 3))
                0:       g.op[i*4 +: 4] = OP_LOAD;
                1:       g.op[i*4 +: 4] = OP_STORE;
                default: g.op[i*4 +: 4] = 4'($urandom);
            endcase
        end
        return g;
    endfunction

    function automatic grp_t mk(logic [3:0] vld, logic [15:0] op);
        grp_t g = rnd_grp();
        g.vld = vld;
        g.op  = op;
        return g;
    endfunction

    task automatic drive(grp_t g);
        cur           = g;
        bus.in_vld    = g.vld;
        bus.in_des    = g.des;
        bus.in_s1     = g.s1;
        bus.in_s2     = g.s2;
        bus.in_op     = g.op;
        bus.in_ime    = g.ime;
        bus.in_branch = g.br;
    endtask

    // Sample just after the negedge, update the model, advance one cycle.
    task automatic cyc(output logic acc);
        beat_t e;
        logic [3:0] m;
        #1;
        acc = bus.in_valid && bus.in_ready;
        if (rst) begin
            exp_q.delete();
            hold_armed = 1'b0;
            acc = 1'b0;
        end else begin
            if (hold_armed) chk("hold", outs(), snap);
            chk("out_valid", 256'(bus.out_valid), 256'(exp_q.size() > 0));
            chk("in_ready", 256'(bus.in_ready),
                256'(exp_q.size() == 0 || (exp_q.size() == 1 && bus.out_ready)));
            if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                m = e.vld;
                chk("vld", 256'(bus.out_vld), 256'(e.vld));
                chk("flags", 256'(flags()), 256'(e.flg));
                chk("tid", 256'(bus.out_tid), 256'(e.tid));
                chk("des", 256'(bus.out_des & 20'(mexp(m, 5))), 256'(e.des & 20'(mexp(m, 5))));
                chk("s1", 256'(bus.out_s1 & 20'(mexp(m, 5))), 256'(e.s1 & 20'(mexp(m, 5))));
                chk("s2", 256'(bus.out_s2 & 20'(mexp(m, 5))), 256'(e.s2 & 20'(mexp(m, 5))));
                chk("op", 256'(bus.out_op & 16'(mexp(m, 4))), 256'(e.op & 16'(mexp(m, 4))));
                chk("ime", 256'(bus.out_ime & mexp(m, 16)), 256'(e.ime & mexp(m, 16)));
                chk("branch", 256'(bus.out_branch & m), 256'(e.br & m));
            end
            hold_armed = bus.out_valid && !bus.out_ready;
            snap = outs();
            if (acc) model_push(cur);
        end
        @(negedge clk);
    endtask

    task automatic send(grp_t g);
        logic acc = 1'b0;
        drive(g);
        bus.in_valid = 1'b1;
        for (int n = 0; n < 50 && !acc; n++) cyc(acc);
        if (!acc) chk("send_timeout", 256'(0), 256'(1));
        bus.in_valid = 1'b0;
    endtask

    initial begin
        logic acc;
        grp_t g;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(rnd_grp());
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 256'(bus.out_valid), 256'(0));
        chk("rst_in_ready", 256'(bus.in_ready), 256'(1));
        chk("rst_tid", 256'(bus.out_tid), 256'(8'he4));
        chk("rst_flags", 256'(flags()), 256'(0));
        chk("rst_fields", 256'({bus.out_vld, bus.out_des, bus.out_op, bus.out_ime}), 256'(0));
        rst = 1'b0;
        @(negedge clk);

        // Only lane 4 loads: untouched, no swap.
        g = mk(4'hF, {OP_LOAD, OP_ALU, OP_ALU, OP_ALU});
        send(g); #1;
        chk("l4_flags", 256'(flags()), 256'(4'b0000));
        chk("l4_tid", 256'(bus.out_tid), 256'(8'b11_10_01_00));
        chk("l4_des", 256'(bus.out_des), 256'(g.des));
        cyc(acc);

        // Only lane 1 stores: untouched, 1<->4 swap requested.
        g = mk(4'hF, {OP_ALU, OP_ALU, OP_ALU, OP_STORE});
        send(g); #1;
        chk("l1_flags", 256'(flags()), 256'(4'b1001));
        chk("l1_des", 256'(bus.out_des), 256'(g.des));
        cyc(acc);

        // Only lane 3 loads: exchanged into lane 1.
        g = mk(4'hF, {OP_ALU, OP_LOAD, OP_ALU, OP_ALU});
        send(g); #1;
        chk("l3_flags", 256'(flags()), 256'(4'b1001));
        chk("l3_tid", 256'(bus.out_tid), 256'(8'b11_00_01_10));
        chk("l3_lane1", 256'(bus.out_des[4:0]), 256'(g.des[14:10]));
        chk("l3_lane3", 256'(bus.out_des[14:10]), 256'(g.des[4:0]));
        cyc(acc);

        // Lanes 2 and 4 load, first beat back-pressured for 3 cycles.
        g = mk(4'hF, {OP_LOAD, OP_ALU, OP_LOAD, OP_ALU});
        send(g);
        bus.out_ready = 1'b0;
        #1;
        chk("split_b1_vld", 256'(bus.out_vld), 256'(4'b0111));
        chk("split_b1_flags", 256'(flags()), 256'(4'b1001));
        chk("split_in_ready", 256'(bus.in_ready), 256'(0));
        repeat (3) cyc(acc);
        bus.out_ready = 1'b1;
        cyc(acc);
        #1;
        chk("split_b2_vld", 256'(bus.out_vld), 256'(4'b1000));
        chk("split_b2_flags", 256'(flags()), 256'(4'b0000));
        cyc(acc);

        // Empty group still yields a beat.
        g = mk(4'h0, {OP_LOAD, OP_LOAD, OP_STORE, OP_LOAD});
        send(g); #1;
        chk("empty_valid", 256'(bus.out_valid), 256'(1));
        chk("empty_vld", 256'(bus.out_vld), 256'(0));
        chk("empty_flags", 256'(flags()), 256'(0));
        cyc(acc);

        // Reset while draining discards the pending load.
        bus.out_ready = 1'b0;
        send(mk(4'hF, {OP_LOAD, OP_ALU, OP_LOAD, OP_ALU}));
        cyc(acc);
        rst = 1'b1;
        cyc(acc);
        rst = 1'b0;
        #1;
        chk("rst_drain_valid", 256'(bus.out_valid), 256'(0));
        chk("rst_drain_ready", 256'(bus.in_ready), 256'(1));
        bus.out_ready = 1'b1;
        repeat (3) cyc(acc);

        // Random traffic with random backpressure.
        for (int n = 0; n < 1500; n++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                drive(rnd_grp());
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            cyc(acc);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (10) cyc(acc);
        chk("drained", 256'(exp_q.size()), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
